// File: rtl/frogger_pkg.sv
// Shared defaults and FSM encoding for the frogger collision logic.
package frogger_pkg;

  localparam int unsigned DEF_NUM_CARS  = 8;
  localparam int unsigned DEF_COORD_W   = 10;
  localparam int unsigned DEF_FROG_SIZE = 16;
  localparam int unsigned DEF_CAR_W     = 32;
  localparam int unsigned DEF_CAR_H     = 16;

  // Scan sequencer states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } sched_state_e;

endpackage

// File: rtl/bbox_overlap.sv
// Combinational axis-aligned box overlap test. Box A has size A_W x A_H,
// box B has size B_W x B_H; both given by their top-left corners.
module bbox_overlap #(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned A_W     = 16,
  parameter int unsigned A_H     = 16,
  parameter int unsigned B_W     = 32,
  parameter int unsigned B_H     = 16
) (
  input  logic [COORD_W-1:0] i_Ax,
  input  logic [COORD_W-1:0] i_Ay,
  input  logic [COORD_W-1:0] i_Bx,
  input  logic [COORD_W-1:0] i_By,
  output logic               o_Overlap
);

  localparam int unsigned EW = COORD_W + 1;

  // One extra bit keeps the far edges from wrapping at the coordinate limit.
  logic [EW-1:0] w_ax, w_ay, w_bx, w_by;
  logic [EW-1:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

  assign w_ax = {1'b0, i_Ax};
  assign w_ay = {1'b0, i_Ay};
  assign w_bx = {1'b0, i_Bx};
  assign w_by = {1'b0, i_By};

  assign w_ax_end = w_ax + EW'(A_W);
  assign w_ay_end = w_ay + EW'(A_H);
  assign w_bx_end = w_bx + EW'(B_W);
  assign w_by_end = w_by + EW'(B_H);

  // Strict compares: boxes that only share an edge do not overlap.
  assign o_Overlap = (w_ax < w_bx_end) && (w_bx < w_ax_end) &&
                     (w_ay < w_by_end) && (w_by < w_ay_end);

endmodule

// File: rtl/collision_scheduler.sv
// Sequential frog-vs-cars collision check: walks the car slots one at a
// time through a single shared overlap comparator, stops at the first hit.
module collision_scheduler
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_CARS  = DEF_NUM_CARS,
  parameter int unsigned COORD_W   = DEF_COORD_W,
  parameter int unsigned FROG_SIZE = DEF_FROG_SIZE,
  parameter int unsigned CAR_W     = DEF_CAR_W,
  parameter int unsigned CAR_H     = DEF_CAR_H,
  localparam int unsigned IDX_W    = $clog2(NUM_CARS)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Start,
  input  logic [COORD_W-1:0] i_Frog_X,
  input  logic [COORD_W-1:0] i_Frog_Y,
  output logic [IDX_W-1:0]   o_Car_Idx,
  input  logic [COORD_W-1:0] i_Car_X,
  input  logic [COORD_W-1:0] i_Car_Y,
  input  logic               i_Car_Valid,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Has_Collided,
  output logic [IDX_W-1:0]   o_Hit_Idx
);

  sched_state_e       r_state;
  sched_state_e       w_next_state;
  logic [COORD_W-1:0] r_frog_x;
  logic [COORD_W-1:0] r_frog_y;
  logic [IDX_W-1:0]   r_idx;
  logic               r_collided;
  logic [IDX_W-1:0]   r_hit_idx;
  logic               w_overlap;
  logic               w_hit;
  logic               w_last;

  bbox_overlap #(
    .COORD_W (COORD_W),
    .A_W     (FROG_SIZE),
    .A_H     (FROG_SIZE),
    .B_W     (CAR_W),
    .B_H     (CAR_H)
  ) u_overlap (
    .i_Ax      (r_frog_x),
    .i_Ay      (r_frog_y),
    .i_Bx      (i_Car_X),
    .i_By      (i_Car_Y),
    .o_Overlap (w_overlap)
  );

  assign w_hit  = i_Car_Valid && w_overlap;
  assign w_last = (r_idx == IDX_W'(NUM_CARS - 1));

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  // NOTE: the default assignment up front means every path drives the
  // signal, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (i_Start) w_next_state = S_FETCH;
      S_FETCH:   w_next_state = S_COMPARE;
      S_COMPARE: if (w_hit || w_last) w_next_state = S_DONE;
                 else                 w_next_state = S_FETCH;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_Busy = 1'b0;
    o_Done = 1'b0;
    case (r_state)
      S_FETCH, S_COMPARE: o_Busy = 1'b1;
      S_DONE:             o_Done = 1'b1;
      default:            ;
    endcase
  end

  // Datapath: frog latch, slot index and the held result.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_frog_x   <= '0;
      r_frog_y   <= '0;
      r_idx      <= '0;
      r_collided <= 1'b0;
      r_hit_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_frog_x   <= i_Frog_X;
            r_frog_y   <= i_Frog_Y;
            r_idx      <= '0;
            r_collided <= 1'b0;
            r_hit_idx  <= '0;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            r_collided <= 1'b1;
            r_hit_idx  <= r_idx;
          end else if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Car_Idx      = r_idx;
  assign o_Has_Collided = r_collided;
  assign o_Hit_Idx      = r_hit_idx;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler (4 slots): directed corner cases plus
// random scans against a box-overlap reference model.
module tb_collision_scheduler;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] frog_x, frog_y;
  logic [IW-1:0] car_idx;
  logic [CW-1:0] car_x, car_y;
  logic          car_v;
  logic          busy, done, collided;
  logic [IW-1:0] hit_idx;

  // Car position store contents, read one cycle after the index.
  logic [CW-1:0] mem_x [N];
  logic [CW-1:0] mem_y [N];
  bit            mem_v [N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  collision_scheduler #(
    .NUM_CARS (N),
    .COORD_W  (CW)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Start        (start),
    .i_Frog_X       (frog_x),
    .i_Frog_Y       (frog_y),
    .o_Car_Idx      (car_idx),
    .i_Car_X        (car_x),
    .i_Car_Y        (car_y),
    .i_Car_Valid    (car_v),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Has_Collided (collided),
    .o_Hit_Idx      (hit_idx)
  );

  // Synchronous-read car store.
  always @(posedge clk) begin
    car_x <= mem_x[car_idx];
    car_y <= mem_y[car_idx];
    car_v <= mem_v[car_idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_car(input int k, input int x, input int y, input bit v);
    mem_x[k] = CW'(x);
    mem_y[k] = CW'(y);
    mem_v[k] = v;
  endtask

  task automatic set_all(input int x, input int y, input bit v);
    for (int k = 0; k < N; k++) set_car(k, x, y, v);
  endtask

  // Reference: first valid slot whose box overlaps the frog, in plain
  // integer arithmetic. Latency counted in cycles after the start cycle.
  function automatic void model(input int fx, input int fy,
                                output bit hit, output int idx, output int lat);
    hit = 1'b0;
    idx = 0;
    lat = 2 * N + 1;
    for (int k = 0; k < N; k++) begin
      int cx, cy;
      cx = int'(mem_x[k]);
      cy = int'(mem_y[k]);
      if (!hit && mem_v[k] && fx < cx + 32 && cx < fx + 16 &&
          fy < cy + 16 && cy < fy + 16) begin
        hit = 1'b1;
        idx = k;
        lat = 3 + 2 * k;
      end
    end
  endfunction

  // Runs one scan. extra_start (1..lat) re-pulses i_Start in that cycle
  // after the start cycle; 0 means no extra pulse. The frog inputs are
  // scrambled during the scan to confirm the latched copy is used.
  task automatic run_scan(input int fx, input int fy, input int extra_start, input string tag);
    bit hit;
    int idx, lat;
    int done_cnt, done_at;
    model(fx, fy, hit, idx, lat);
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    frog_x = CW'(fx);
    frog_y = CW'(fy);
    start  = 1'b1;
    for (int n = 1; n <= 2 * N + 4; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n <= lat + 1) check({tag, " busy"}, busy, n < lat);
      @(negedge clk);
      start  = (n == extra_start);
      frog_x = CW'($urandom);
      frog_y = CW'($urandom);
    end
    start = 1'b0;
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " done_latency"}, done_at, lat);
    check({tag, " collided"}, collided, hit);
    check({tag, " hit_idx"}, hit_idx, idx);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    frog_x = '0;
    frog_y = '0;
    set_all(100, 100, 1'b1);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst collided", collided, 0);
    check("rst hit_idx", hit_idx, 0);
    check("rst car_idx", car_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full scan, no hit.
    run_scan(0, 0, 0, "nohit");

    // Hit on slot 2 only.
    set_all(600, 600, 1'b1);
    set_car(2, 30, 45, 1'b1);
    run_scan(40, 50, 0, "hit2");

    // Right-edge boundary on slot 0.
    set_all(600, 600, 1'b1);
    set_car(0, 30, 0, 1'b1);
    run_scan(62, 0, 0, "edge62");
    run_scan(61, 0, 0, "edge61");
    set_car(0, 30, 0, 1'b0);
    run_scan(61, 0, 0, "invalid0");

    // Coordinate limit: no wrap-around.
    set_all(500, 500, 1'b1);
    set_car(0, 1015, 0, 1'b1);
    run_scan(1020, 0, 0, "top_hit");
    run_scan(5, 0, 0, "top_nowrap");

    // Start pulses during the scan and in the done cycle are ignored.
    set_all(600, 600, 1'b1);
    run_scan(0, 0, 4, "restart_busy");
    run_scan(0, 0, 2 * N + 1, "restart_done");
    set_car(1, 0, 0, 1'b1);
    run_scan(0, 0, 5, "restart_hit_done");

    // Reset mid-scan.
    set_all(600, 600, 1'b1);
    set_car(3, 10, 10, 1'b1);
    @(negedge clk);
    frog_x = CW'(12);
    frog_y = CW'(12);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst collided", collided, 0);
    check("midrst hit_idx", hit_idx, 0);
    check("midrst car_idx", car_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen = 0;
      for (int n = 0; n < 2 * N + 4; n++) begin
        @(posedge clk);
        #1;
        if (done || busy) seen++;
      end
      check("midrst quiet", seen, 0);
    end
    run_scan(12, 12, 0, "after_rst");

    // Random scans against the reference model.
    for (int it = 0; it < 30; it++) begin
      int fx, fy, ex;
      fx = int'($urandom_range(0, 1023));
      fy = int'($urandom_range(0, 1023));
      for (int k = 0; k < N; k++) begin
        int cx, cy;
        if ($urandom_range(0, 1) == 1) begin
          cx = (fx + int'($urandom_range(0, 70)) - 45) & 1023;
          cy = (fy + int'($urandom_range(0, 40)) - 25) & 1023;
        end else begin
          cx = int'($urandom_range(0, 1023));
          cy = int'($urandom_range(0, 1023));
        end
        set_car(k, cx, cy, $urandom_range(0, 3) != 0);
      end
      ex = int'($urandom_range(0, 3));
      run_scan(fx, fy, ex, $sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter NUM_CARS, default 8, number of car slots scanned per check (2..16).
REQ-002 Parameter COORD_W, default 10, bit width of every X/Y coordinate.
REQ-003 Parameter FROG_SIZE, default 16, frog box width and height in pixels.
REQ-004 Parameter CAR_W, default 32, car box width in pixels.
REQ-005 Parameter CAR_H, default 16, car box height in pixels.
REQ-006 Port i_Clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 Port i_Rst  in  1  reset, asynchronous, active-high.
REQ-008 Port i_Start  in  1  one-cycle request to run a collision check.
REQ-009 Port i_Frog_X / i_Frog_Y  in  COORD_W each  frog top-left corner.
REQ-010 Port o_Car_Idx  out  clog2(NUM_CARS)  car slot being fetched from the car position store.
REQ-011 Port i_Car_X / i_Car_Y  in  COORD_W each  top-left corner of slot o_Car_Idx, valid one cycle after o_Car_Idx changes.
REQ-012 Port i_Car_Valid  in  1  slot o_Car_Idx is active, same timing as i_Car_X.
REQ-013 Port o_Busy  out  1  scan in progress.
REQ-014 Port o_Done  out  1  one-cycle pulse: result valid.
REQ-015 Port o_Has_Collided  out  1  result of last completed check.
REQ-016 Port o_Hit_Idx  out  clog2(NUM_CARS)  first colliding slot; 0 when no hit.

Function
REQ-017 FSM states IDLE, FETCH, COMPARE, DONE; exactly one shared overlap comparator.
REQ-018 IDLE: o_Busy=0; on i_Start=1 latch frog X/Y, set slot index 0, clear o_Has_Collided and o_Hit_Idx, go FETCH.
REQ-019 FETCH: o_Car_Idx = current index, o_Busy=1; go COMPARE next cycle.
REQ-020 COMPARE: if i_Car_Valid and overlap, set o_Has_Collided=1, o_Hit_Idx=index, go DONE (early exit).
REQ-021 COMPARE without hit: index==NUM_CARS-1 -> DONE; else index+1 -> FETCH.
REQ-022 DONE: o_Done=1 for exactly one cycle, o_Busy=0, go IDLE; result holds until next accepted i_Start.
REQ-023 Timing: i_Start sampled at cycle T -> slot k compared at T+2+2k; o_Done at T+2N+1 with no hit, T+3+2k on hit at slot k.
REQ-024 Overlap iff fx < cx+CAR_W and cx < fx+FROG_SIZE and fy < cy+CAR_H and cy < fy+FROG_SIZE; edge-adjacent boxes do not overlap.
REQ-025 Sums computed at COORD_W+1 bits, unsigned; no wrap-around at the coordinate limit.
REQ-026 i_Start while o_Busy=1 or in DONE is ignored; no queueing.
REQ-027 Frog moves during a scan do not affect the running scan (latched values used).
REQ-028 Invalid slots never produce a hit regardless of coordinates.

Reset
REQ-029 i_Rst=1 forces IDLE immediately: o_Busy=0, o_Done=0, o_Has_Collided=0, o_Hit_Idx=0, o_Car_Idx=0.
REQ-030 Reset mid-scan aborts without o_Done; first i_Start after release runs a full scan.

Structure
REQ-031 Shared package frogger_pkg holds COORD_W, FROG_SIZE, CAR_W, CAR_H, NUM_CARS defaults and the FSM state encoding.
REQ-032 Overlap test is a sub-module bbox_overlap (combinational, width-extended compares), instantiated once.

Verification (NUM_CARS=4, COORD_W=10, defaults otherwise)
REQ-033 Frog (0,0), all cars valid at (100,100), start at T -> o_Done at T+9, o_Has_Collided=0, o_Hit_Idx=0.
REQ-034 Frog (40,50), car2 valid at (30,45), others far -> o_Done at T+7, o_Has_Collided=1, o_Hit_Idx=2.
REQ-035 Car0 (30,0): frog (62,0) -> no hit; frog (61,0) -> hit idx 0; car0 overlapping but i_Car_Valid=0 -> no hit.
REQ-036 Car0 (1015,0): frog (1020,0) -> hit; frog (5,0) -> no hit (no wrap).
REQ-037 i_Start pulsed during scan -> ignored, single o_Done; i_Rst at T+4 -> outputs zero, no o_Done, next start completes normally.
